alu_issue_ctrl: RTL and testbench

- Sequential issue/retire stage in front of the combinational 8-bit ALU (`alu_8bit`).
- Accepts operation commands over a valid/ready handshake and registers the operands and opcode driving the ALU.
- Holds the ALU inputs stable for a per-opcode latency budget, then captures the 16-bit result, carry and status flags into a response register with its own valid/ready handshake.
- Detects divide-by-zero and illegal opcodes itself; never forwards an undefined ALU result.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_if.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire stage: opcodes, default latencies
// and the FSM state encoding.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_MUL = 3'b101;
  localparam op_t OP_DIV = 3'b110;
  localparam op_t OP_ILL = 3'b111;

  localparam int LAT_SIMPLE_DEF = 1;
  localparam int LAT_MUL_DEF    = 3;
  localparam int LAT_DIV_DEF    = 4;
  localparam int CNT_W          = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle for alu_issue_ctrl.
// cmd_use_carry exists only when ALU_CARRY_CHAIN_EN is defined.
interface alu_issue_ctrl_if #(parameter int TAG_W = 4);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic             rsp_cout;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_dz;
  logic             rsp_ill;

`ifdef ALU_CARRY_CHAIN_EN
  logic             cmd_use_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, cmd_use_carry, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_tag,
           rsp_zero, rsp_neg, rsp_dz, rsp_ill
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, cmd_use_carry, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_tag,
           rsp_zero, rsp_neg, rsp_dz, rsp_ill
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_tag,
           rsp_zero, rsp_neg, rsp_dz, rsp_ill
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_tag,
           rsp_zero, rsp_neg, rsp_dz, rsp_ill
  );
`endif

endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/retire stage in front of the combinational alu_8bit: registers operands,
// waits a per-opcode latency, captures the result. Carry chaining: ALU_CARRY_CHAIN_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int LAT_SIMPLE = LAT_SIMPLE_DEF,
  parameter int LAT_MUL    = LAT_MUL_DEF,
  parameter int LAT_DIV    = LAT_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_ctrl_if.slave        bus,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [2:0]             alu_op,
  output logic                   alu_cin,
  input  logic [15:0]            alu_result,
  input  logic                   alu_cout,
  output logic                   busy
);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_result_q;
  logic             rsp_cout_q;
  logic             rsp_zero_q;
  logic             rsp_neg_q;
  logic             rsp_dz_q;
  logic             rsp_ill_q;

  logic accept;
  logic div_zero;
  logic capture;

  function automatic logic [CNT_W-1:0] lat_of(input op_t op);
    case (op)
      OP_MUL:  return CNT_W'(LAT_MUL);
      OP_DIV:  return CNT_W'(LAT_DIV);
      default: return CNT_W'(LAT_SIMPLE);
    endcase
  endfunction

  // A held response can be retired and replaced by a new command in the same edge.
  assign bus.cmd_ready = rst_n & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign div_zero      = (bus.cmd_op == OP_DIV) && (bus.cmd_b == 8'd0);
  assign capture       = (state_q == EXEC) && (cnt_q == CNT_W'(1));
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
      rsp_dz_q     <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else if (accept) begin
      alu_a  <= bus.cmd_a;
      alu_b  <= bus.cmd_b;
      alu_op <= bus.cmd_op;
      tag_q  <= bus.cmd_tag;
      // Faults never reach the ALU result path: they answer straight away with a zero result.
      if ((bus.cmd_op == OP_ILL) || div_zero) begin
        state_q      <= RESP;
        cnt_q        <= '0;
        rsp_valid_q  <= 1'b1;
        rsp_result_q <= '0;
        rsp_cout_q   <= 1'b0;
        rsp_zero_q   <= 1'b1;
        rsp_neg_q    <= 1'b0;
        rsp_dz_q     <= div_zero;
        rsp_ill_q    <= (bus.cmd_op == OP_ILL);
      end else begin
        state_q     <= EXEC;
        cnt_q       <= lat_of(bus.cmd_op);
        rsp_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (capture) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_cout_q   <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) & alu_cout;
            rsp_zero_q   <= (alu_result == 16'd0);
            rsp_neg_q    <= alu_result[15];
            rsp_dz_q     <= 1'b0;
            rsp_ill_q    <= 1'b0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        IDLE:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_neg    = rsp_neg_q;
  assign bus.rsp_dz     = rsp_dz_q;
  assign bus.rsp_ill    = rsp_ill_q;

`ifdef ALU_CARRY_CHAIN_EN
  logic use_carry_q;
  logic carry_q;

  // carry_q remembers the last add/sub carry so a chained add can continue a wider sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      use_carry_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      if (accept) begin
        use_carry_q <= bus.cmd_use_carry;
      end
      if (capture && ((alu_op == OP_ADD) || (alu_op == OP_SUB))) begin
        carry_q <= alu_cout;
      end
    end
  end

  assign alu_cin = (state_q == EXEC) && (alu_op == OP_ADD) && use_carry_q && carry_q;
`else
  assign alu_cin = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural alu_8bit beside it
// and a queue of expected responses.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        busy;

  alu_issue_ctrl_if #(.TAG_W(4)) bus ();

  alu_issue_ctrl #(.TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for alu_8bit: signed arithmetic, zero-extended logic ops.
  logic signed [15:0] sa;
  logic signed [15:0] sb;
  logic [8:0]         s9;

  always_comb begin
    sa         = {{8{alu_a[7]}}, alu_a};
    sb         = {{8{alu_b[7]}}, alu_b};
    s9         = 9'd0;
    alu_result = 16'd0;
    alu_cout   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        s9         = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result = sa + sb + {15'd0, alu_cin};
        alu_cout   = s9[8];
      end
      OP_SUB: begin
        s9         = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        alu_result = sa - sb;
        alu_cout   = s9[8];
      end
      OP_AND: alu_result = {8'd0, alu_a & alu_b};
      OP_OR:  alu_result = {8'd0, alu_a | alu_b};
      OP_XOR: alu_result = {8'd0, alu_a ^ alu_b};
      OP_MUL: alu_result = sa * sb;
      OP_DIV: begin
        if (alu_b != 8'd0) alu_result = sa / sb;
        else               alu_result = 16'hDEAD;
      end
      default: alu_result = 16'hBAD0;
    endcase
  end

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        dz;
    logic        ill;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  int   compare_cnt  = 0;
  int   mismatch_cnt = 0;

  function automatic rsp_t mkExp(input logic [15:0] r, input logic c, input logic dz,
                                 input logic ill, input logic [3:0] t);
    rsp_t e;
    e.result = r;
    e.cout   = c;
    e.zero   = (r == 16'd0);
    e.neg    = r[15];
    e.dz     = dz;
    e.ill    = ill;
    e.tag    = t;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one command at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input op_t op, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] tag, input rsp_t exp);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
    #1;
    checkOutput("cmd_ready_on_issue", bus.cmd_ready, 1);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic popCheck();
    rsp_t e;
    checkOutput("sb_has_entry", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("rsp_valid",  bus.rsp_valid,  1);
      checkOutput("rsp_result", bus.rsp_result, e.result);
      checkOutput("rsp_cout",   bus.rsp_cout,   e.cout);
      checkOutput("rsp_zero",   bus.rsp_zero,   e.zero);
      checkOutput("rsp_neg",    bus.rsp_neg,    e.neg);
      checkOutput("rsp_dz",     bus.rsp_dz,     e.dz);
      checkOutput("rsp_ill",    bus.rsp_ill,    e.ill);
      checkOutput("rsp_tag",    bus.rsp_tag,    e.tag);
    end
  endtask

  // Counts edges after the accept until rsp_valid; the stage must look busy meanwhile.
  task automatic waitRsp(input int lat);
    int k = 0;
    while (!bus.rsp_valid && k < 20) begin
      checkOutput("busy_exec", busy, 1);
      checkOutput("cmd_ready_exec", bus.cmd_ready, 0);
      tick();
      k++;
    end
    checkOutput("latency", k, lat);
    popCheck();
  endtask

  task automatic retire();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_retire", bus.rsp_valid, 0);
  endtask

  op_t        logic_ops [2] = '{OP_AND, OP_OR};
  logic [7:0] logic_a   [2] = '{8'hCC, 8'h80};
  logic [7:0] logic_b   [2] = '{8'hAA, 8'h01};
  logic [15:0] logic_r  [2] = '{16'h0088, 16'h0081};

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.cmd_tag   = 4'd0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_CARRY_CHAIN_EN
    bus.cmd_use_carry = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_cmd_ready", bus.cmd_ready, 0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_busy",      busy,          0);
    checkOutput("reset_alu_a",     alu_a,         0);
    checkOutput("reset_rsp_result", bus.rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);

    $display("[TB] add 100+27");
    applyStimulus(OP_ADD, 8'd100, 8'd27, 4'd1, mkExp(16'h007F, 1'b0, 1'b0, 1'b0, 4'd1));
    waitRsp(1);
    checkOutput("alu_cin_default", alu_cin, 0);
    retire();

    $display("[TB] mul -3*5");
    applyStimulus(OP_MUL, 8'hFD, 8'd5, 4'd2, mkExp(16'hFFF1, 1'b0, 1'b0, 1'b0, 4'd2));
    waitRsp(3);
    retire();

    $display("[TB] div -100/7");
    applyStimulus(OP_DIV, 8'h9C, 8'd7, 4'hA, mkExp(16'hFFF2, 1'b0, 1'b0, 1'b0, 4'hA));
    waitRsp(4);
    retire();

    $display("[TB] div by zero");
    applyStimulus(OP_DIV, 8'd7, 8'd0, 4'd3, mkExp(16'h0000, 1'b0, 1'b1, 1'b0, 4'd3));
    tick();
    popCheck();
    retire();

    $display("[TB] illegal opcode");
    applyStimulus(OP_ILL, 8'h12, 8'h34, 4'd4, mkExp(16'h0000, 1'b0, 1'b0, 1'b1, 4'd4));
    tick();
    popCheck();
    retire();

    $display("[TB] logic ops");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(logic_ops[i], logic_a[i], logic_b[i], 4'(i + 11),
                    mkExp(logic_r[i], 1'b0, 1'b0, 1'b0, 4'(i + 11)));
      waitRsp(1);
      retire();
    end

    $display("[TB] backpressure sub 5-9 then xor");
    applyStimulus(OP_SUB, 8'd5, 8'd9, 4'd5, mkExp(16'hFFFC, 1'b0, 1'b0, 1'b0, 4'd5));
    waitRsp(1);
    bus.cmd_op    = OP_XOR;
    bus.cmd_a     = 8'hF0;
    bus.cmd_b     = 8'h0F;
    bus.cmd_tag   = 4'd6;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_rsp_valid",  bus.rsp_valid,  1);
      checkOutput("stall_rsp_result", bus.rsp_result, 16'hFFFC);
      checkOutput("stall_rsp_tag",    bus.rsp_tag,    4'd5);
      checkOutput("stall_cmd_ready",  bus.cmd_ready,  0);
      checkOutput("stall_alu_b",      alu_b,          8'd9);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("retire_cmd_ready", bus.cmd_ready, 1);
    exp_q.push_back(mkExp(16'h00FF, 1'b0, 1'b0, 1'b0, 4'd6));
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checkOutput("b2b_alu_op", alu_op, OP_XOR);
    waitRsp(1);
    retire();

    $display("[TB] reset during div");
    applyStimulus(OP_DIV, 8'd100, 8'd7, 4'd7, mkExp(16'h000E, 1'b0, 1'b0, 1'b0, 4'd7));
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("rst_busy",       busy,           0);
    checkOutput("rst_rsp_valid",  bus.rsp_valid,  0);
    checkOutput("rst_cmd_ready",  bus.cmd_ready,  0);
    checkOutput("rst_alu_a",      alu_a,          0);
    checkOutput("rst_alu_op",     alu_op,         0);
    checkOutput("rst_rsp_result", bus.rsp_result, 0);
    checkOutput("rst_rsp_tag",    bus.rsp_tag,    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("no_rsp_after_reset", bus.rsp_valid, 0);
    end
    applyStimulus(OP_ADD, 8'd1, 8'd1, 4'd8, mkExp(16'h0002, 1'b0, 1'b0, 1'b0, 4'd8));
    waitRsp(1);
    retire();

`ifdef ALU_CARRY_CHAIN_EN
    $display("[TB] carry chain");
    bus.cmd_use_carry = 1'b0;
    applyStimulus(OP_ADD, 8'hFF, 8'h01, 4'd9, mkExp(16'h0000, 1'b1, 1'b0, 1'b0, 4'd9));
    waitRsp(1);
    retire();
    bus.cmd_use_carry = 1'b1;
    applyStimulus(OP_ADD, 8'h00, 8'h00, 4'hC, mkExp(16'h0001, 1'b0, 1'b0, 1'b0, 4'hC));
    checkOutput("chain_alu_cin", alu_cin, 1);
    waitRsp(1);
    retire();
    bus.cmd_use_carry = 1'b0;
`endif

    checkOutput("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compare_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
